// File: rtl/boa_mem_responder.sv
// ---------------------------------------------------------------------------
// boa_mem_responder
//
// Word-organised memory slave with a fixed, parameterised access latency.
// An access is active while re=1 or any we bit is set. The initiator holds
// the request until ready pulses for one cycle. The memory array has no reset
// so it maps onto a single-port synchronous block RAM with read-first
// behaviour.
//
// Parameters:
//   alen       - bus address width in bits
//   base       - first byte address served
//   depth_log2 - log2 of the number of 32-bit words stored
//   wait_cyc   - extra wait cycles per access (0..15)
//
// Ports:
//   clk    in   single clock, all state changes on its rising edge
//   rst    in   synchronous active-high reset
//   re     in   read request
//   we     in   byte-lane write enables, lane i is wdata[8i+7:8i]
//   addr   in   byte address, addr[1:0] ignored
//   wdata  in   write data
//   ready  out  the access completes in this cycle
//   rdata  out  read word during ready, zero otherwise and when err=1
//   err    out  the access was out of range, valid while ready=1
// ---------------------------------------------------------------------------
module boa_mem_responder #(
  parameter int              alen       = 32,
  parameter logic [alen-1:0] base       = 'h4000_0000,
  parameter int              depth_log2 = 12,
  parameter int              wait_cyc   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            re,
  input  logic [3:0]      we,
  input  logic [alen-1:0] addr,
  input  logic [31:0]     wdata,
  output logic            ready,
  output logic [31:0]     rdata,
  output logic            err
);

  localparam int words = 1 << depth_log2;

  // Range bounds carry one extra bit so base + size cannot wrap to zero.
  localparam logic [alen:0] lo_bound = {1'b0, base};
  localparam logic [alen:0] hi_bound = lo_bound + ((alen + 1)'(1) << (depth_log2 + 2));

  localparam logic [3:0] wait_load = (wait_cyc > 0) ? 4'(wait_cyc - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic err_reg;
  logic [31:0] rd_q_reg;

  logic [31:0] mem [words];

  logic active;
  logic in_range;
  logic enter_resp;
  logic [alen:0] addr_ext;
  logic [depth_log2-1:0] idx;
  logic [3:0] lane_wr;

  assign active   = re | (|we);
  assign addr_ext = {1'b0, addr};
  assign in_range = (addr_ext >= lo_bound) && (addr_ext < hi_bound);

  // Word index relative to base; base is word aligned, so subtracting at
  // word granularity gives the same index as a full byte subtraction.
  assign idx = addr[depth_log2+1:2] - base[depth_log2+1:2];

  // Out-of-range writes are dropped lane by lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_wr[gi] = we[gi] & in_range;
    end
  endgenerate

  // Next-state logic. A withdrawn request in WAIT abandons the access
  // before the counter is looked at, so no commit ever happens for it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (active) begin
          if (wait_cyc == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = wait_load;
          end
        end
      end
      WAIT: begin
        if (!active) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        // A request still held here is picked up again from IDLE.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // err only ever holds during the RESP cycle.
      err_reg   <= enter_resp & ~in_range;
    end
  end

  // Single-port RAM, read-first: the word latched for rdata is the
  // pre-write content when a read and write share an access.
  always_ff @(posedge clk) begin
    if (enter_resp && !rst) begin
      rd_q_reg <= mem[idx];
      for (int i = 0; i < 4; i++) begin
        if (lane_wr[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign ready = (state_reg == RESP);
  assign err   = err_reg;
  // The RAM output register is not reset; gating keeps rdata at zero
  // outside RESP and for out-of-range accesses.
  assign rdata = (ready && !err_reg) ? rd_q_reg : 32'd0;

endmodule
